// File: rtl/pipe_skid_stage_pkg.sv
// Shared defaults and pointer helpers for the skid-buffered pipeline stage.
package pipe_skid_stage_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32'd32;
    localparam int unsigned DEFAULT_SKID_DEPTH = 32'd2;

    function automatic int unsigned ptr_width(input int unsigned depth);
        if (depth > 32'd1) begin
            return $clog2(depth);
        end else begin
            return 32'd1;
        end
    endfunction

    // Circular increment; depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr + 32'd1 >= depth) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_skid_stage_skid_fifo.sv
// Circular skid buffer sitting behind the output register of pipe_skid_stage.
module skid_fifo
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned SKID_DEPTH = DEFAULT_SKID_DEPTH,
    localparam int unsigned PW        = ptr_width(SKID_DEPTH),
    localparam int unsigned OW        = $clog2(SKID_DEPTH + 32'd1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [OW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_r [SKID_DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [OW-1:0]    count_r;

    // Pointer and occupancy update; reset and flush both empty the buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_i) begin
                tail_r <= PW'(wrap_inc(32'(tail_r), SKID_DEPTH));
            end
            if (pop_i) begin
                head_r <= PW'(wrap_inc(32'(head_r), SKID_DEPTH));
            end
            case ({push_i, pop_i})
                2'b10:   count_r <= count_r + OW'(1);
                2'b01:   count_r <= count_r - OW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && rst_ni && !flush_i) begin
            mem_r[tail_r] <= push_data_i;
        end
    end

    assign head_o  = mem_r[head_r];
    assign empty_o = (count_r == '0);
    assign count_o = count_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Registered valid/ready pipeline stage: output register plus skid buffer, full throughput.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned SKID_DEPTH = DEFAULT_SKID_DEPTH,
    parameter int unsigned CW         = $clog2(SKID_DEPTH + 32'd2)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned OW = $clog2(SKID_DEPTH + 32'd1);

    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CW-1:0]    count_r;

    logic             accept_s;
    logic             xfer_s;
    logic             load_s;
    logic             push_s;
    logic             pop_s;
    logic             skid_empty_s;
    logic [WIDTH-1:0] skid_head_s;
    logic [OW-1:0]    skid_cnt_s;
    logic [OW-1:0]    skid_cnt_nxt_s;
    logic             out_valid_nxt_s;
    logic [WIDTH-1:0] out_data_nxt_s;

    assign accept_s = in_valid_i && in_ready_r && rst_ni && !flush_i;
    assign xfer_s   = out_valid_r && out_ready_i;
    assign load_s   = !out_valid_r || xfer_s;
    assign pop_s    = load_s && !skid_empty_s;
    // A beat bypasses the skid only when the output loads and nothing older is waiting.
    assign push_s   = accept_s && !(load_s && skid_empty_s);

    skid_fifo #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (push_s),
        .push_data_i (in_data_i),
        .pop_i       (pop_s),
        .head_o      (skid_head_s),
        .empty_o     (skid_empty_s),
        .count_o     (skid_cnt_s)
    );

    // Next-state of output register and skid occupancy.
    always_comb begin
        skid_cnt_nxt_s  = skid_cnt_s;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        case ({push_s, pop_s})
            2'b10:   skid_cnt_nxt_s = skid_cnt_s + OW'(1);
            2'b01:   skid_cnt_nxt_s = skid_cnt_s - OW'(1);
            default: skid_cnt_nxt_s = skid_cnt_s;
        endcase
        if (load_s) begin
            out_valid_nxt_s = !skid_empty_s || accept_s;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
        if (pop_s) begin
            out_data_nxt_s = skid_head_s;
        end else if (load_s && accept_s) begin
            out_data_nxt_s = in_data_i;
        end else begin
            out_data_nxt_s = out_data_r;
        end
    end

    // Control registers: reset dominates flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            count_r     <= '0;
        end else if (flush_i) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            count_r     <= '0;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            in_ready_r  <= (skid_cnt_nxt_s < OW'(SKID_DEPTH));
            count_r     <= CW'(out_valid_nxt_s) + CW'(skid_cnt_nxt_s);
        end
    end

    // Output payload register, unreset.
    always_ff @(posedge clk_i) begin
        out_data_r <= out_data_nxt_s;
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign count_o     = count_r;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: depth-2 instance for directed cases, depth-3 for wrap.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;

    logic [31:0] in_data_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [31:0] out_data_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(32), .SKID_DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .count_o     (count)
    );

    pipe_skid_stage #(.WIDTH(32), .SKID_DEPTH(3)) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (1'b0),
        .in_data_i   (in_data_b),
        .in_valid_i  (in_valid_b),
        .in_ready_o  (in_ready_b),
        .out_data_o  (out_data_b),
        .out_valid_o (out_valid_b),
        .out_ready_i (out_ready_b),
        .count_o     (count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic v, input logic [31:0] d,
                               input logic [1:0] c, input logic r);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            check({tag, "_data"}, out_data, d);
        end
        check({tag, "_count"}, {30'd0, count}, {30'd0, c});
        check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, r});
    endtask

    initial begin
        int sent_b;
        int exp_b;
        int max_b;
        logic acc_b;
        logic xfr_b;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        in_valid_b = 1'b0; in_data_b = 32'd0; out_ready_b = 1'b0;
        tick(); tick();
        check_state("reset", 1'b0, 32'd0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_state("post_reset", 1'b0, 32'd0, 2'd0, 1'b1);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            tick();
            check_state("stream", 1'b1, 32'(i), 2'd1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check_state("stream_drain", 1'b0, 32'd0, 2'd0, 1'b1);

        // Stall fill.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; tick(); check_state("fill_a", 1'b1, 32'hA, 2'd1, 1'b1);
        in_data = 32'hB; tick(); check_state("fill_b", 1'b1, 32'hA, 2'd2, 1'b1);
        in_data = 32'hC; tick(); check_state("fill_c", 1'b1, 32'hA, 2'd3, 1'b0);
        in_data = 32'hD; tick(); check_state("fill_d1", 1'b1, 32'hA, 2'd3, 1'b0);
        tick();                  check_state("fill_d2", 1'b1, 32'hA, 2'd3, 1'b0);
        out_ready = 1'b1;
        tick(); check_state("drain_b", 1'b1, 32'hB, 2'd2, 1'b1);
        tick(); check_state("drain_c", 1'b1, 32'hC, 2'd2, 1'b1);
        in_valid = 1'b0;
        tick(); check_state("drain_d", 1'b1, 32'hD, 2'd1, 1'b1);
        tick(); check_state("drain_empty", 1'b0, 32'd0, 2'd0, 1'b1);

        // Flush while full.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 32'h10 + 32'(i);
            tick();
        end
        check_state("flush_full", 1'b1, 32'h11, 2'd3, 1'b0);
        flush = 1'b1; in_data = 32'hE;
        tick();
        check_state("flush", 1'b0, 32'd0, 2'd0, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_state("flush_after", 1'b0, 32'd0, 2'd0, 1'b1);
        in_valid = 1'b1; in_data = 32'h21;
        tick();
        check_state("flush_refill", 1'b1, 32'h21, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();

        // Reset mid-stream.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h31; tick();
        in_data = 32'h32; tick();
        check_state("pre_reset", 1'b1, 32'h31, 2'd2, 1'b1);
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        check_state("mid_reset", 1'b0, 32'd0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_state("reset_release", 1'b0, 32'd0, 2'd0, 1'b1);
        out_ready = 1'b1;
        tick();
        check_state("reset_discard", 1'b0, 32'd0, 2'd0, 1'b1);

        // Wrap: depth 3, random backpressure, incrementing data.
        sent_b = 0; exp_b = 0; max_b = 0;
        for (int cyc = 0; cyc < 6000 && exp_b < 1000; cyc++) begin
            in_valid_b  = (sent_b < 1000);
            in_data_b   = 32'(sent_b);
            out_ready_b = 1'($urandom_range(0, 1));
            acc_b = in_valid_b && in_ready_b;
            xfr_b = out_valid_b && out_ready_b;
            if (xfr_b) begin
                check("wrap_data", out_data_b, 32'(exp_b));
                exp_b++;
            end
            if (acc_b) begin
                sent_b++;
            end
            tick();
            if (int'(count_b) > max_b) begin
                max_b = int'(count_b);
            end
        end
        in_valid_b = 1'b0;
        check("wrap_all_received", 32'(exp_b), 32'd1000);
        check("wrap_count_max_ok", {31'd0, (max_b <= 4)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload bit width; legal range >= 1.
REQ-002 Parameter SKID_DEPTH, default 2: skid entries behind the output register; legal range >= 1.
REQ-003 Parameter CW, default $clog2(SKID_DEPTH+2): width of count_o.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 flush_i  input  1  synchronous discard of all held and incoming beats.
REQ-007 in_data_i  input  WIDTH  upstream payload.
REQ-008 in_valid_i  input  1  upstream payload valid.
REQ-009 in_ready_o  output  1  registered upstream ready.
REQ-010 out_data_o  output  WIDTH  registered downstream payload.
REQ-011 out_valid_o  output  1  registered downstream valid.
REQ-012 out_ready_i  input  1  downstream ready.
REQ-013 count_o  output  CW  beats held (output register plus skid), registered.

Function
REQ-014 Upstream accept = in_valid_i && in_ready_o && rst_ni && !flush_i; downstream transfer = out_valid_o && out_ready_i.
REQ-015 Beats leave in exact acceptance order; no duplication, no loss except by flush or reset.
REQ-016 Output register loads when empty or transferring this cycle: from skid head if skid non-empty, else directly from an accepted input beat (bypass).
REQ-017 An accepted beat not loaded into the output register is written to the skid tail the same edge.
REQ-018 Latency: beat accepted in cycle N with storage empty is presented on out_data_o/out_valid_o in cycle N+1.
REQ-019 in_ready_o next value = (next skid occupancy < SKID_DEPTH); every accept is therefore safe regardless of out_ready_i, and the skid never overflows.
REQ-020 Throughput: with out_ready_i held 1, one beat per cycle sustained indefinitely; skid occupancy stays 0.
REQ-021 Full: output valid plus SKID_DEPTH skid entries gives count_o = SKID_DEPTH+1 and in_ready_o = 0 from the following cycle.
REQ-022 Empty: out_valid_o = 0, count_o = 0, out_data_o holds its last value (don't-care).
REQ-023 Skid is a circular buffer; head/tail pointers wrap modulo SKID_DEPTH, and non-power-of-two depths are supported.
REQ-024 Simultaneous skid push and pop in one cycle leaves skid occupancy unchanged.
REQ-025 out_data_o stays stable while out_valid_o && !out_ready_i.
REQ-026 flush_i = 1: the downstream transfer that cycle still completes, the incoming beat is dropped, and all skid/output contents are discarded; next cycle out_valid_o = 0, count_o = 0, in_ready_o = 1.
REQ-027 flush_i has no effect while rst_ni = 0.

Reset
REQ-028 While rst_ni = 0 at an edge: out_valid_o <= 0, in_ready_o <= 0, count_o <= 0, and skid pointers and occupancy <= 0.
REQ-029 in_ready_o rises to 1 on the first edge with rst_ni = 1.
REQ-030 Reset asserted mid-operation discards all held beats.
REQ-031 Payload registers need no reset.

Structure
REQ-032 No new package typedefs; WIDTH is chosen by the instantiator (e.g. $bits of a payload struct from cpu_common).
REQ-033 The skid storage, pointers and occupancy form one sub-module, skid_fifo (parameters WIDTH, SKID_DEPTH; push/pop/flush in; head/empty/count out); output register and ready logic stay in pipe_skid_stage.

Verification
REQ-034 Bench default: WIDTH=32, SKID_DEPTH=2.
REQ-035 Streaming: out_ready_i=1, push 0x1..0x8 back to back -> 0x1..0x8 on consecutive cycles starting 1 cycle after the first accept; count_o <= 1 throughout; in_ready_o stays 1.
REQ-036 Stall fill: out_ready_i=0, offer 0xA,0xB,0xC,0xD continuously -> accepts 0xA,0xB,0xC only; count_o=3; in_ready_o=0 from the cycle after 0xC; out_data_o=0xA stable; then out_ready_i=1 -> 0xA,0xB,0xC,0xD in order.
REQ-037 Flush: with count_o=3, assert flush_i for 1 cycle while offering 0xE -> next cycle out_valid_o=0, count_o=0, in_ready_o=1; 0xE never appears.
REQ-038 Wrap: SKID_DEPTH=3, random out_ready_i (50%), 1000 beats of incrementing data -> output sequence matches input exactly; count_o never exceeds 4.
REQ-039 Reset: drop rst_ni for 1 cycle mid-stream with count_o=2 -> next cycle out_valid_o=0, in_ready_o=0, count_o=0; the cycle after, in_ready_o=1.
